dsp_mac_pipe: RTL and testbench

DSP_MAC_PIPE -- requirements
Module: dsp_mac_pipe

---
 rtl/dsp_mac_pipe.sv | 153 +++++++++++++++
 tb/tb_dsp_mac_pipe.sv | 325 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dsp_mac_pipe.sv
`default_nettype none
// ============================================================================
// Module   : dsp_mac_pipe
// Brief    : 4-stage signed multiply-accumulate with a single global advance.
//            Define DSP_MAC_SATURATE_EN to clamp on overflow and report the flag.
// Revision : 1.0 - initial release
// ============================================================================
module dsp_mac_pipe #(
  parameter int A_WIDTH = 25,
  parameter int B_WIDTH = 18,
  parameter int P_WIDTH = 48
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic signed [A_WIDTH-1:0] a,
  input  logic signed [B_WIDTH-1:0] b,
  input  logic                      acc_en,
  input  logic                      acc_first,
  input  logic                      acc_last,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic signed [P_WIDTH-1:0] p,
  output logic                      overflow
);

  localparam int M_WIDTH = A_WIDTH + B_WIDTH;

  logic                      adv;

  logic                      s1_valid_q;
  logic signed [A_WIDTH-1:0] s1_a_q;
  logic signed [B_WIDTH-1:0] s1_b_q;
  logic                      s1_en_q;
  logic                      s1_first_q;
  logic                      s1_last_q;

  logic                      s2_valid_q;
  logic signed [M_WIDTH-1:0] s2_prod_q;
  logic                      s2_en_q;
  logic                      s2_first_q;
  logic                      s2_last_q;

  logic signed [P_WIDTH-1:0] prod_ext;
  logic signed [P_WIDTH-1:0] sum;
  logic signed [P_WIDTH-1:0] acc_q;
  logic signed [P_WIDTH-1:0] acc_d;
  logic                      acc_ovf_q;
  logic                      acc_ovf_d;
  logic                      s3_valid_q;
  logic                      s3_valid_d;

  logic                      out_valid_q;
  logic signed [P_WIDTH-1:0] p_q;
  logic                      ovf_q;

  // The whole pipe moves only when the output register can be vacated.
  assign adv      = !out_valid_q || out_ready;
  assign in_ready = adv;

  generate
    if (P_WIDTH > M_WIDTH) begin : g_sext
      assign prod_ext = {{(P_WIDTH-M_WIDTH){s2_prod_q[M_WIDTH-1]}}, s2_prod_q};
    end else begin : g_no_sext
      assign prod_ext = s2_prod_q;
    end
  endgenerate

  assign sum = acc_q + prod_ext;

`ifdef DSP_MAC_SATURATE_EN
  localparam logic signed [P_WIDTH-1:0] P_MAX = {1'b0, {(P_WIDTH-1){1'b1}}};
  localparam logic signed [P_WIDTH-1:0] P_MIN = {1'b1, {(P_WIDTH-1){1'b0}}};

  logic add_ovf;
  assign add_ovf = (acc_q[P_WIDTH-1] == prod_ext[P_WIDTH-1]) &&
                   (sum[P_WIDTH-1] != acc_q[P_WIDTH-1]);
`endif

  always_comb begin
    acc_d      = acc_q;
    acc_ovf_d  = acc_ovf_q;
    s3_valid_d = 1'b0;
    if (s2_valid_q) begin
      s3_valid_d = !s2_en_q || s2_last_q;
      if (!s2_en_q || s2_first_q) begin
        acc_d     = prod_ext;
        acc_ovf_d = 1'b0;
      end else begin
`ifdef DSP_MAC_SATURATE_EN
        // Clamp direction follows the sign both operands shared.
        acc_d     = add_ovf ? (acc_q[P_WIDTH-1] ? P_MIN : P_MAX) : sum;
        acc_ovf_d = acc_ovf_q | add_ovf;
`else
        acc_d     = sum;
        acc_ovf_d = 1'b0;
`endif
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_valid_q  <= 1'b0;
      s1_a_q      <= '0;
      s1_b_q      <= '0;
      s1_en_q     <= 1'b0;
      s1_first_q  <= 1'b0;
      s1_last_q   <= 1'b0;
      s2_valid_q  <= 1'b0;
      s2_prod_q   <= '0;
      s2_en_q     <= 1'b0;
      s2_first_q  <= 1'b0;
      s2_last_q   <= 1'b0;
      acc_q       <= '0;
      acc_ovf_q   <= 1'b0;
      s3_valid_q  <= 1'b0;
      out_valid_q <= 1'b0;
      p_q         <= '0;
      ovf_q       <= 1'b0;
    end else if (adv) begin
      s1_valid_q  <= in_valid;
      s1_a_q      <= a;
      s1_b_q      <= b;
      s1_en_q     <= acc_en;
      s1_first_q  <= acc_first;
      s1_last_q   <= acc_last;

      s2_valid_q  <= s1_valid_q;
      s2_prod_q   <= s1_a_q * s1_b_q;
      s2_en_q     <= s1_en_q;
      s2_first_q  <= s1_first_q;
      s2_last_q   <= s1_last_q;

      acc_q       <= acc_d;
      acc_ovf_q   <= acc_ovf_d;
      s3_valid_q  <= s3_valid_d;

      out_valid_q <= s3_valid_q;
      if (s3_valid_q) begin
        p_q   <= acc_q;
        ovf_q <= acc_ovf_q;
      end
    end
  end

  assign out_valid = out_valid_q;
  assign p         = p_q;
  assign overflow  = ovf_q;

endmodule
`default_nettype wire

// File: tb/tb_dsp_mac_pipe.sv
`default_nettype none
// ============================================================================
// Module   : tb_dsp_mac_pipe
// Brief    : Scoreboard bench for dsp_mac_pipe built with P_WIDTH = 43.
// Revision : 1.0 - initial release
// ============================================================================
module tb_dsp_mac_pipe;

  localparam int AW = 25;
  localparam int BW = 18;
  localparam int PW = 43;

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic                 in_valid;
  logic                 in_ready;
  logic signed [AW-1:0] a;
  logic signed [BW-1:0] b;
  logic                 acc_en;
  logic                 acc_first;
  logic                 acc_last;
  logic                 out_valid;
  logic                 out_ready;
  logic signed [PW-1:0] p;
  logic                 overflow;

  int vectors     = 0;
  int miscompares = 0;
  int cyc         = 0;

  logic signed [PW-1:0] exp_p[$];
  bit                   exp_o[$];
  logic signed [PW-1:0] obs_p[$];
  bit                   obs_o[$];
  int                   obs_c[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  dsp_mac_pipe #(.A_WIDTH(AW), .B_WIDTH(BW), .P_WIDTH(PW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .acc_en    (acc_en),
    .acc_first (acc_first),
    .acc_last  (acc_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .p         (p),
    .overflow  (overflow)
  );

  // Every completed transfer lands in the observed queues.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && out_valid === 1'b1 && out_ready === 1'b1) begin
      obs_p.push_back(p);
      obs_o.push_back(overflow);
      obs_c.push_back(cyc);
    end
  end

  task automatic send(input logic signed [AW-1:0] ia, input logic signed [BW-1:0] ib,
                      input bit en, input bit f, input bit l, output int acc_cyc);
    int g = 0;
    in_valid = 1'b1; a = ia; b = ib; acc_en = en; acc_first = f; acc_last = l;
    @(negedge clk);
    while (in_ready !== 1'b1 && g < 100) begin g++; @(negedge clk); end
    if (in_ready !== 1'b1) begin
      vectors++; miscompares++;
      $display("FAIL send_timeout in_ready=%0b required=1", in_ready);
    end
    acc_cyc = cyc;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_obs(input int n, output bit ok);
    int g = 0;
    while (obs_p.size() < n && g < 300) begin @(negedge clk); g++; end
    ok = (obs_p.size() >= n);
    @(posedge clk); #1;
  endtask

  task automatic flush();
    exp_p.delete(); exp_o.delete(); obs_p.delete(); obs_o.delete(); obs_c.delete();
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    a = '0; b = '0; acc_en = 1'b0; acc_first = 1'b0; acc_last = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL rst_out_valid got=%0b required=0", out_valid); end
    vectors++; if (p !== '0) begin miscompares++; $display("FAIL rst_p got=%0d required=0", p); end
    vectors++; if (overflow !== 1'b0) begin miscompares++; $display("FAIL rst_overflow got=%0b required=0", overflow); end
    @(posedge clk); #1; rst_n = 1'b1;
    @(posedge clk); @(negedge clk);
    vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("FAIL rst_in_ready got=%0b required=1", in_ready); end
    @(posedge clk); #1;
  endtask

  task automatic test_multiply();
    int c0, cx; bit ok;
    logic signed [PW-1:0] ep, op; bit eo, oo;
    send(25'sd3, -18'sd5, 1'b0, 1'b0, 1'b0, c0);          exp_p.push_back(-43'sd15);  exp_o.push_back(1'b0);
    send(-25'sd7, -18'sd9, 1'b0, 1'b1, 1'b1, cx);         exp_p.push_back(43'sd63);   exp_o.push_back(1'b0);
    send(25'sd1000, 18'sd131071, 1'b0, 1'b0, 1'b0, cx);   exp_p.push_back(43'sd131071000); exp_o.push_back(1'b0);
    wait_obs(3, ok);
    vectors++; if (!ok) begin miscompares++; $display("FAIL mul_timeout results=%0d required=3", obs_p.size()); end
    if (obs_c.size() > 0) begin
      vectors++;
      if (obs_c[0] - c0 !== 4) begin miscompares++; $display("FAIL mul_latency got=%0d required=4", obs_c[0] - c0); end
    end
    while (exp_p.size() > 0 && obs_p.size() > 0) begin
      ep = exp_p.pop_front(); eo = exp_o.pop_front();
      op = obs_p.pop_front(); oo = obs_o.pop_front(); void'(obs_c.pop_front());
      vectors++;
      if (op !== ep || oo !== eo) begin miscompares++; $display("FAIL mul_result p=%0d ovf=%0b required p=%0d ovf=%0b", op, oo, ep, eo); end
    end
    flush();
  endtask

  task automatic test_accumulate();
    int c4, cx; bit ok;
    logic signed [PW-1:0] ep, op; bit eo, oo;
    for (int i = 1; i <= 4; i++) send(AW'(i), 18'sd2, 1'b1, i == 1, i == 4, c4);
    exp_p.push_back(43'sd20); exp_o.push_back(1'b0);
    wait_obs(1, ok);
    repeat (8) @(posedge clk); #1;
    vectors++; if (obs_p.size() !== 1) begin miscompares++; $display("FAIL acc_count got=%0d required=1", obs_p.size()); end
    if (obs_c.size() > 0) begin
      vectors++;
      if (obs_c[0] - c4 !== 4) begin miscompares++; $display("FAIL acc_latency got=%0d required=4", obs_c[0] - c4); end
    end
    // Continuing without acc_first keeps building on the last sum.
    send(25'sd1, 18'sd1, 1'b1, 1'b0, 1'b1, cx); exp_p.push_back(43'sd21); exp_o.push_back(1'b0);
    send(25'sd5, 18'sd1, 1'b1, 1'b0, 1'b0, cx);
    send(25'sd0, 18'sd1, 1'b1, 1'b0, 1'b1, cx); exp_p.push_back(43'sd26); exp_o.push_back(1'b0);
    wait_obs(3, ok);
    vectors++; if (!ok) begin miscompares++; $display("FAIL acc_timeout results=%0d required=3", obs_p.size()); end
    while (exp_p.size() > 0 && obs_p.size() > 0) begin
      ep = exp_p.pop_front(); eo = exp_o.pop_front();
      op = obs_p.pop_front(); oo = obs_o.pop_front(); void'(obs_c.pop_front());
      vectors++;
      if (op !== ep || oo !== eo) begin miscompares++; $display("FAIL acc_result p=%0d ovf=%0b required p=%0d ovf=%0b", op, oo, ep, eo); end
    end
    flush();
  endtask

  task automatic test_one_term();
    int cx; bit ok;
    logic signed [PW-1:0] ep, op; bit eo, oo;
    send(25'sh1000000, 18'sh20000, 1'b1, 1'b1, 1'b1, cx);
    exp_p.push_back(43'sd2199023255552); exp_o.push_back(1'b0);
    wait_obs(1, ok);
    vectors++; if (!ok) begin miscompares++; $display("FAIL one_timeout results=%0d required=1", obs_p.size()); end
    while (exp_p.size() > 0 && obs_p.size() > 0) begin
      ep = exp_p.pop_front(); eo = exp_o.pop_front();
      op = obs_p.pop_front(); oo = obs_o.pop_front(); void'(obs_c.pop_front());
      vectors++;
      if (op !== ep || oo !== eo) begin miscompares++; $display("FAIL one_result p=%0d ovf=%0b required p=%0d ovf=%0b", op, oo, ep, eo); end
    end
    flush();
  endtask

  task automatic test_back_to_back();
    int idx = 0, c = 0, stalls = 0, av, bv;
    bit holding = 1'b0;
    logic signed [PW-1:0] held, ep, op; bit eo, oo;
    for (int i = 0; i < 10; i++) begin
      av = 1000 * i - 4321; bv = 37 - 9 * i;
      exp_p.push_back(PW'(longint'(av) * longint'(bv))); exp_o.push_back(1'b0);
    end
    while ((idx < 10 || obs_p.size() < 10) && c < 100) begin
      out_ready = !(c >= 5 && c <= 8);
      if (idx < 10) begin
        in_valid = 1'b1; a = AW'(1000 * idx - 4321); b = BW'(37 - 9 * idx);
        acc_en = 1'b0; acc_first = 1'b0; acc_last = 1'b0;
      end else in_valid = 1'b0;
      @(negedge clk);
      if (out_valid === 1'b1 && out_ready === 1'b0) begin
        stalls++;
        vectors++; if (in_ready !== 1'b0) begin miscompares++; $display("FAIL stall_in_ready got=%0b required=0", in_ready); end
        if (holding) begin
          vectors++; if (p !== held) begin miscompares++; $display("FAIL stall_p_stable got=%0d required=%0d", p, held); end
        end
        held = p; holding = 1'b1;
      end else holding = 1'b0;
      if (in_valid && in_ready) idx++;
      @(posedge clk); #1; c++;
    end
    in_valid = 1'b0; out_ready = 1'b1;
    vectors++; if (stalls !== 4) begin miscompares++; $display("FAIL stall_cycles got=%0d required=4", stalls); end
    vectors++; if (obs_p.size() !== 10) begin miscompares++; $display("FAIL b2b_count got=%0d required=10", obs_p.size()); end
    while (exp_p.size() > 0 && obs_p.size() > 0) begin
      ep = exp_p.pop_front(); eo = exp_o.pop_front();
      op = obs_p.pop_front(); oo = obs_o.pop_front(); void'(obs_c.pop_front());
      vectors++;
      if (op !== ep || oo !== eo) begin miscompares++; $display("FAIL b2b_result p=%0d ovf=%0b required p=%0d ovf=%0b", op, oo, ep, eo); end
    end
    flush();
  endtask

  task automatic test_saturate();
    int cx; bit ok;
    longint x;
    logic signed [PW-1:0] ep, op, w; bit eo, oo;
    x = ((64'sd1 <<< 24) - 1) * ((64'sd1 <<< 17) - 1);
    send(25'sh0FFFFFF, 18'sh1FFFF, 1'b1, 1'b1, 1'b0, cx);
    send(25'sh0FFFFFF, 18'sh1FFFF, 1'b1, 1'b0, 1'b0, cx);
    send(25'sh0FFFFFF, 18'sh1FFFF, 1'b1, 1'b0, 1'b1, cx);
    send(-25'sd1, 18'sd1, 1'b1, 1'b0, 1'b1, cx);
`ifdef DSP_MAC_SATURATE_EN
    w = 43'sh3FFFFFFFFFF;
    exp_p.push_back(w);     exp_o.push_back(1'b1);
    exp_p.push_back(w - 1); exp_o.push_back(1'b1);
`else
    w = PW'(3 * x);
    exp_p.push_back(w);     exp_o.push_back(1'b0);
    exp_p.push_back(w - 1); exp_o.push_back(1'b0);
`endif
    wait_obs(2, ok);
    vectors++; if (!ok) begin miscompares++; $display("FAIL sat_timeout results=%0d required=2", obs_p.size()); end
    while (exp_p.size() > 0 && obs_p.size() > 0) begin
      ep = exp_p.pop_front(); eo = exp_o.pop_front();
      op = obs_p.pop_front(); oo = obs_o.pop_front(); void'(obs_c.pop_front());
      vectors++;
      if (op !== ep || oo !== eo) begin miscompares++; $display("FAIL sat_result p=%0d ovf=%0b required p=%0d ovf=%0b", op, oo, ep, eo); end
    end
    flush();
  endtask

  task automatic test_reset_mid();
    int cx; bit ok;
    logic signed [PW-1:0] ep, op; bit eo, oo;
    send(25'sd1, 18'sd1, 1'b1, 1'b1, 1'b0, cx);
    send(25'sd2, 18'sd1, 1'b1, 1'b0, 1'b0, cx);
    rst_n = 1'b0;
    repeat (2) begin
      @(negedge clk);
      vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL mid_rst_out_valid got=%0b required=0", out_valid); end
    end
    @(posedge clk); #1; rst_n = 1'b1;
    repeat (10) @(posedge clk); #1;
    vectors++; if (obs_p.size() !== 0) begin miscompares++; $display("FAIL mid_rst_results got=%0d required=0", obs_p.size()); end
    flush();
    send(25'sd7, 18'sd7, 1'b1, 1'b1, 1'b1, cx);
    exp_p.push_back(43'sd49); exp_o.push_back(1'b0);
    wait_obs(1, ok);
    vectors++; if (!ok) begin miscompares++; $display("FAIL mid_timeout results=%0d required=1", obs_p.size()); end
    while (exp_p.size() > 0 && obs_p.size() > 0) begin
      ep = exp_p.pop_front(); eo = exp_o.pop_front();
      op = obs_p.pop_front(); oo = obs_o.pop_front(); void'(obs_c.pop_front());
      vectors++;
      if (op !== ep || oo !== eo) begin miscompares++; $display("FAIL mid_result p=%0d ovf=%0b required p=%0d ovf=%0b", op, oo, ep, eo); end
    end
    flush();
  endtask

  task automatic test_random();
    int cx, av, bv, n;
    bit en, f, l, ok, done = 1'b0;
    longint macc = 0, prod;
    logic signed [PW-1:0] ep, op; bit eo, oo;
    fork
      begin
        for (int i = 0; i < 40; i++) begin
          av = int'($urandom_range(4000)) - 2000;
          bv = int'($urandom_range(4000)) - 2000;
          en = (i == 0) ? 1'b1 : 1'($urandom_range(1));
          f  = (i == 0) ? 1'b1 : ($urandom_range(3) == 0);
          l  = 1'($urandom_range(1));
          prod = longint'(av) * longint'(bv);
          if (!en) begin
            macc = prod; exp_p.push_back(PW'(macc)); exp_o.push_back(1'b0);
          end else begin
            macc = f ? prod : macc + prod;
            if (l) begin exp_p.push_back(PW'(macc)); exp_o.push_back(1'b0); end
          end
          send(AW'(av), BW'(bv), en, f, l, cx);
        end
        done = 1'b1;
      end
      begin
        while (!done) begin @(posedge clk); #1; out_ready = 1'($urandom_range(1)); end
        out_ready = 1'b1;
      end
    join
    n = exp_p.size();
    wait_obs(n, ok);
    repeat (6) @(posedge clk); #1;
    vectors++; if (obs_p.size() !== n) begin miscompares++; $display("FAIL rnd_count got=%0d required=%0d", obs_p.size(), n); end
    while (exp_p.size() > 0 && obs_p.size() > 0) begin
      ep = exp_p.pop_front(); eo = exp_o.pop_front();
      op = obs_p.pop_front(); oo = obs_o.pop_front(); void'(obs_c.pop_front());
      vectors++;
      if (op !== ep || oo !== eo) begin miscompares++; $display("FAIL rnd_result p=%0d ovf=%0b required p=%0d ovf=%0b", op, oo, ep, eo); end
    end
    flush();
  endtask

  initial begin
    test_reset();
    test_multiply();
    test_accumulate();
    test_one_term();
    test_back_to_back();
    test_saturate();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog simulation did not finish, time=%0t", $time);
    $fatal(1);
  end

endmodule
`default_nettype wire
